// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bus of the round-robin mux arbiter: requests and data in,
// one-hot grant, mux select, forwarded data bit and busy flag out.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       data_out;
    logic       busy;

    modport master (
        output req,
        output data_in,
        input  grant,
        input  sel,
        input  data_out,
        input  busy
    );

    modport slave (
        input  req,
        input  data_in,
        output grant,
        output sel,
        output data_out,
        output busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 single-bit mux between four requesters,
// with a hold limit that forces a hand-over when someone else is waiting.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    mux4_rr_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         grant_q, grant_d;
    logic [1:0]         sel_q,   sel_d;
    logic [1:0]         ptr_q,   ptr_d;
    logic               busy_q,  busy_d;
    logic [CNT_W-1:0]   hold_q,  hold_d;

    logic [3:0]         others_s;
    logic [1:0]         next_ptr_s;
    logic               expired_s;

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    assign others_s   = bus.req & ~onehot(sel_q);
    assign next_ptr_s = sel_q + 2'd1;
    assign expired_s  = (hold_q == CNT_W'(MAX_HOLD - 1));

    // Next-state selection: idle arbitration, release, hold expiry, or keep.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req != 4'b0000) begin
                    sel_d   = rr_pick(bus.req, ptr_q);
                    grant_d = onehot(rr_pick(bus.req, ptr_q));
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    state_d = ST_GRANT;
                end else begin
                    grant_d = 4'b0000;
                    sel_d   = 2'b00;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!bus.req[sel_q]) begin
                    // Release wins over expiry; new requests join this search.
                    ptr_d  = next_ptr_s;
                    hold_d = '0;
                    if (others_s != 4'b0000) begin
                        sel_d   = rr_pick(others_s, next_ptr_s);
                        grant_d = onehot(rr_pick(others_s, next_ptr_s));
                        busy_d  = 1'b1;
                        state_d = ST_GRANT;
                    end else begin
                        grant_d = 4'b0000;
                        sel_d   = 2'b00;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (expired_s) begin
                    hold_d = '0;
                    if (others_s != 4'b0000) begin
                        ptr_d   = next_ptr_s;
                        sel_d   = rr_pick(others_s, next_ptr_s);
                        grant_d = onehot(rr_pick(others_s, next_ptr_s));
                    end else begin
                        ptr_d   = ptr_q;
                    end
                end else begin
                    hold_d = hold_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
                sel_d   = 2'b00;
                busy_d  = 1'b0;
                hold_d  = '0;
                ptr_d   = 2'b00;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b00;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.sel      = sel_q;
    assign bus.busy     = busy_q;
    assign bus.data_out = busy_q & bus.data_in[sel_q];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios followed by
// random traffic, compared against an owner/tenure reference model.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Reference model: current owner (-1 when idle), priority pointer, and
    // number of edges the owner has held the grant so far.
    int   m_owner;
    int   m_ptr;
    int   m_tenure;

    mux4_rr_arbiter_if bus_if ();

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic int search(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic rst, input logic [3:0] r);
        logic [3:0] oth;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_tenure = 0;
        end else if (m_owner < 0) begin
            if (r != 4'b0000) begin
                m_owner  = search(r, m_ptr);
                m_tenure = 1;
            end
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                m_ptr    = (m_owner + 1) % 4;
                m_owner  = search(oth, m_ptr);
                m_tenure = (m_owner < 0) ? 0 : 1;
            end else if (m_tenure >= MAX_HOLD) begin
                if (oth != 4'b0000) begin
                    m_ptr   = (m_owner + 1) % 4;
                    m_owner = search(oth, m_ptr);
                end
                m_tenure = 1;
            end else begin
                m_tenure++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [3:0] e_grant;
        logic [1:0] e_sel;
        logic       e_busy;
        logic       e_do;
        e_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        e_sel   = (m_owner < 0) ? 2'b00 : 2'(m_owner);
        e_busy  = (m_owner >= 0);
        e_do    = (m_owner < 0) ? 1'b0 : bus_if.data_in[m_owner];
        check({tag, "_grant"}, 32'(bus_if.grant), 32'(e_grant));
        check({tag, "_sel"},   32'(bus_if.sel),   32'(e_sel));
        check({tag, "_busy"},  32'(bus_if.busy),  32'(e_busy));
        check({tag, "_dout"},  32'(bus_if.data_out), 32'(e_do));
        check({tag, "_onehot"}, 32'($onehot0(bus_if.grant)), 32'd1);
    endtask

    task automatic step(input string tag);
        model_edge(reset, bus_if.req);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus_if.req = 4'b0000;
        bus_if.data_in = 4'b0000;
        m_owner = -1; m_ptr = 0; m_tenure = 0;
        step("rst0");
        step("rst1");
        check("rst_grant", 32'(bus_if.grant), 32'd0);
        check("rst_busy",  32'(bus_if.busy),  32'd0);
        reset = 1'b0;

        // Single requester 2 with data pass-through.
        bus_if.req = 4'b0100;
        bus_if.data_in = 4'b0100;
        step("t1");
        check("t1_grant", 32'(bus_if.grant), 32'h4);
        check("t1_sel",   32'(bus_if.sel),   32'd2);
        check("t1_dout1", 32'(bus_if.data_out), 32'd1);
        bus_if.data_in = 4'b0000;
        #1;
        check("t1_dout0", 32'(bus_if.data_out), 32'd0);

        // All requesting: 8 cycles each, order 0,1,2,3,0.
        reset = 1'b1; step("t2r"); reset = 1'b0;
        bus_if.req = 4'b1111;
        bus_if.data_in = 4'b1010;
        for (int c = 0; c < 40; c++) begin
            step("t2");
            check("t2_order", 32'(bus_if.sel), 32'((c / 8) % 4));
        end

        // Owner 3 releases while requester 0 waits: wrap with no idle gap.
        n = 0;
        while (m_owner != 3 && n < 40) begin
            step("t3w");
            n++;
        end
        check("t3_reach_owner3", 32'(m_owner), 32'd3);
        bus_if.req = 4'b0001;
        step("t3");
        check("t3_grant", 32'(bus_if.grant), 32'h1);
        check("t3_busy",  32'(bus_if.busy),  32'd1);

        // Lone requester keeps the grant across hold-limit restarts.
        reset = 1'b1; step("t4r"); reset = 1'b0;
        bus_if.req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            step("t4");
            check("t4_grant", 32'(bus_if.grant), 32'h2);
        end

        // Release to idle, then pointer 3 wraps to pick requester 0.
        reset = 1'b1; step("t5r"); reset = 1'b0;
        bus_if.data_in = 4'b1111;
        bus_if.req = 4'b0100;
        step("t5a");
        bus_if.req = 4'b0000;
        step("t5b");
        check("t5_idle_grant", 32'(bus_if.grant), 32'd0);
        check("t5_idle_dout",  32'(bus_if.data_out), 32'd0);
        bus_if.req = 4'b0101;
        step("t5c");
        check("t5_wrap_grant", 32'(bus_if.grant), 32'h1);

        // Reset mid-grant drops owner 1; pointer returns to 0.
        reset = 1'b1; step("t6r"); reset = 1'b0;
        bus_if.req = 4'b0010;
        step("t6a");
        check("t6_owner1", 32'(bus_if.grant), 32'h2);
        bus_if.req = 4'b0011;
        reset = 1'b1;
        step("t6b");
        check("t6_rst_grant", 32'(bus_if.grant), 32'd0);
        check("t6_rst_sel",   32'(bus_if.sel),   32'd0);
        reset = 1'b0;
        step("t6c");
        check("t6_grant0", 32'(bus_if.grant), 32'h1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) bus_if.req = 4'($urandom);
            bus_if.data_in = 4'($urandom);
            reset = ($urandom_range(0, 63) == 0);
            step("rnd");
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 single-bit mux between four requesters.
- Each requester raises a request bit. The block grants exactly one requester at a time, drives the mux select lines, and forwards the granted requester's data bit.
- A hold limit stops any one requester from monopolising the mux.
- Sits between the board switch/key inputs (requests, data) and the LED output path.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while another requester is waiting; legal range 2..255
CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
req  input  4  request bits; req[i]=1 means requester i wants the mux
data_in  input  4  data bits; data_in[i] belongs to requester i
grant  output  4  one-hot grant (registered); all zero when idle
sel  output  2  mux select = index of current owner (registered); S1=sel[1], S0=sel[0]
data_out  output  1  data_in[sel] when busy, else 0 (combinational from registered sel/busy)
busy  output  1  1 while any grant is active (registered)

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: grant=4'b0000, sel=2'b00, busy=0, data_out=0, priority pointer ptr=0, hold_cnt=0, state=IDLE.
- Reset asserted mid-grant: state is dropped at the next edge with no completion of the current grant.
- Internal state: ptr (2 bits) = highest-priority index for the next arbitration; hold_cnt; owner = sel.
- Round-robin search: scan indices ptr, ptr+1, ptr+2, ptr+3, each mod 4 (3 wraps to 0). The first index with req set wins.

State IDLE:
- Taken when no grant is active.
- If req != 0 at edge t: the winner of the search from ptr is granted. grant/sel/busy are valid after edge t (one-cycle latency from request to grant). hold_cnt=0. Go to GRANT.
- If req == 0: stay in IDLE, outputs at reset values except ptr, which is unchanged.

State GRANT:
- Owner o = sel. On each edge:
  a) req[o]=0 (release): ptr<=o+1. If any other req is set, grant the search winner from o+1 in the same edge (back-to-back, no idle cycle), hold_cnt=0. Otherwise go to IDLE with grant=0 and busy=0.
  b) req[o]=1 and hold_cnt==MAX_HOLD-1 and another req is set (expiry): ptr<=o+1, grant the search winner from o+1 (never o), hold_cnt=0.
  c) req[o]=1 and hold_cnt==MAX_HOLD-1 and no other req: o keeps the grant, hold_cnt=0.
  d) Otherwise: keep the grant, hold_cnt<=hold_cnt+1.
- Simultaneous events: release and expiry on the same edge are handled as release. New requests arriving in the same cycle as a release take part in that edge's search.
- A requester that drops and re-raises req while not owner waits for its turn; requests are not queued.

Invariants (always):
- grant is one-hot or zero.
- grant==0 iff busy==0.
- busy=1 implies grant[sel]=1.
- data_out equals data_in[sel]&busy in the same cycle; data changes pass through with no latency.

Test Plan:
- Reset then req=4'b0100 held -> after one edge grant=4'b0100, sel=2, busy=1; data_in=4'b0100 gives data_out=1, data_in=4'b0000 gives data_out=0.
- req=4'b1111 constant, MAX_HOLD=8 -> grant order 0,1,2,3,0, each owner for exactly 8 cycles; never two bits set.
- Owner 3 releases while req[0]=1 -> next edge grant=4'b0001 with no idle cycle (pointer wraps 3->0).
- Only req[1] held for 20 cycles -> grant stays 4'b0010 throughout; hold_cnt restarts with no gap or glitch.
- Owner 2 releases and no other req -> next edge grant=0, busy=0, data_out=0; later req=4'b0101 -> grant=4'b0001, because ptr=3 and the search wraps 3->0.
- reset pulsed for one cycle mid-grant (owner 1) -> next edge all outputs at reset values; with req=4'b0011 still asserted, the following edge grants requester 0 (ptr back to 0).
